toy_bus_itcm_arb: RTL

//  Shares one single-port ITCM macro between NUM_REQ ToyBus requesters, e.g. port 0 = ifetch, port 1 = LSU.

---
 rtl/toy_bus_itcm_arb.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/toy_bus_itcm_arb.sv
// Round-robin arbiter sharing one single-port ITCM between NUM_REQ ToyBus requesters.
// Tracks one outstanding read and holds its response until the owner accepts it.
module toy_bus_itcm_arb #(
  parameter int NUM_REQ  = 2,
  parameter int DATA_W   = 256,
  parameter int ADDR_W   = 32,
  parameter int MEM_AW   = 24,
  parameter int ADDR_LSB = 5,
  parameter int SB_W     = 10,
  parameter int ID_W     = 4,
  parameter int NODE_ID  = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_vld,
  output logic [NUM_REQ-1:0]          req_rdy,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_strb,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_opcode,
  input  logic [NUM_REQ*ID_W-1:0]     req_src_id,
  input  logic [NUM_REQ*SB_W-1:0]     req_sideband,
  output logic [NUM_REQ-1:0]          ack_vld,
  input  logic [NUM_REQ-1:0]          ack_rdy,
  output logic                        ack_opcode,
  output logic [DATA_W-1:0]           ack_data,
  output logic [SB_W-1:0]             ack_sideband,
  output logic [ID_W-1:0]             ack_src_id,
  output logic [ID_W-1:0]             ack_tgt_id,
  output logic                        mem_en,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_wr_en,
  output logic [DATA_W-1:0]           mem_wr_data,
  output logic [DATA_W/8-1:0]         mem_wr_byte_en,
  output logic [SB_W-1:0]             mem_req_sideband,
  input  logic [DATA_W-1:0]           mem_rd_data,
  input  logic [SB_W-1:0]             mem_ack_sideband
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RSP} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, gnt_idx, rsp_owner;
  logic               gnt_vld, rd_ok, rd_gnt, owner_ack;
  logic [NUM_REQ-1:0] elig;
  logic [ID_W-1:0]    gnt_src, rsp_tgt;
  logic [DATA_W-1:0]  rsp_data;
  logic [SB_W-1:0]    rsp_sb;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^req_addr;

  assign owner_ack = ack_rdy[rsp_owner];
  assign rd_ok     = rst_n && ((state == S_IDLE) || ((state == S_RSP) && owner_ack));
  assign elig      = rst_n ? (req_vld & (req_opcode | {NUM_REQ{rd_ok}})) : '0;

  // First eligible requester at or after rr_ptr, with wrap.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    req_rdy          = '0;
    mem_en           = 1'b0;
    mem_addr         = '0;
    mem_wr_en        = 1'b0;
    mem_wr_data      = '0;
    mem_wr_byte_en   = '0;
    mem_req_sideband = '0;
    gnt_src          = '0;
    rd_gnt           = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_vld && (gnt_idx == PTR_W'(i))) begin
        req_rdy[i]       = 1'b1;
        mem_en           = 1'b1;
        mem_addr         = ADDR_W'(req_addr[i*ADDR_W+ADDR_LSB +: MEM_AW]);
        mem_wr_en        = req_opcode[i];
        mem_wr_data      = req_data[i*DATA_W +: DATA_W];
        mem_wr_byte_en   = req_strb[i*STRB_W +: STRB_W];
        mem_req_sideband = req_sideband[i*SB_W +: SB_W];
        gnt_src          = req_src_id[i*ID_W +: ID_W];
        rd_gnt           = !req_opcode[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (rd_gnt) state_nxt = S_RD_WAIT;
      S_RD_WAIT: state_nxt = S_RSP;
      S_RSP:     if (owner_ack) state_nxt = rd_gnt ? S_RD_WAIT : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Owner/target are taken at grant; a new read can only be granted as the old response leaves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      rsp_owner <= '0;
      rsp_tgt   <= '0;
      rsp_data  <= '0;
      rsp_sb    <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_vld) rr_ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      if (rd_gnt) begin
        rsp_owner <= gnt_idx;
        rsp_tgt   <= gnt_src;
      end
      if (state == S_RD_WAIT) begin
        rsp_data <= mem_rd_data;
        rsp_sb   <= mem_ack_sideband;
      end
    end
  end

  always_comb begin
    ack_vld = '0;
    if (rst_n && (state == S_RSP)) ack_vld[rsp_owner] = 1'b1;
  end

  assign ack_opcode   = 1'b0;
  assign ack_data     = rsp_data;
  assign ack_sideband = rsp_sb;
  assign ack_src_id   = ID_W'(NODE_ID);
  assign ack_tgt_id   = rsp_tgt;

endmodule
